// File: rtl/mlp_pkg.sv
// mlp_pkg: shared width defaults and saturation limits for the mlp_v1 datapath.
// Holds the default DATA_W/ADDR_W/ACC_W/FRAC_BITS and the signed clamp bounds
// for the accumulator and the written neuron at those default widths.
package mlp_pkg;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 12;
  localparam int ACC_W     = 24;
  localparam int FRAC_BITS = 4;
  localparam int DATA_MAX  = (2 ** (DATA_W - 1)) - 1;
  localparam int DATA_MIN  = -(2 ** (DATA_W - 1));
  localparam int ACC_MAX   = (2 ** (ACC_W - 1)) - 1;
  localparam int ACC_MIN   = -(2 ** (ACC_W - 1));
endpackage

// File: rtl/mac_neuron_unit_if.sv
// mac_neuron_unit_if: control strobes, memory read data and output-neuron write port.
// master: control_unit/memory side (drives strobes and read data, observes write port).
// slave : mac_neuron_unit side (consumes strobes and data, drives write port and flags).
interface mac_neuron_unit_if #(
  parameter int DATA_W = mlp_pkg::DATA_W,
  parameter int ADDR_W = mlp_pkg::ADDR_W
);
  logic                     reset_mult_acc;
  logic                     write_neuron;
  logic [ADDR_W-1:0]        output_neuron_addr;
  logic                     done;
  logic signed [DATA_W-1:0] neuron_data;
  logic signed [DATA_W-1:0] weight_data;
  logic                     neuron_wr_en;
  logic [ADDR_W-1:0]        neuron_wr_addr;
  logic signed [DATA_W-1:0] neuron_wr_data;
  logic                     layer_done;
  logic                     acc_overflow;
  modport master (
    output reset_mult_acc, write_neuron, output_neuron_addr, done, neuron_data, weight_data,
    input  neuron_wr_en, neuron_wr_addr, neuron_wr_data, layer_done, acc_overflow
  );
  modport slave (
    input  reset_mult_acc, write_neuron, output_neuron_addr, done, neuron_data, weight_data,
    output neuron_wr_en, neuron_wr_addr, neuron_wr_data, layer_done, acc_overflow
  );
endinterface

// File: rtl/ctrl_delay.sv
// ctrl_delay: DEPTH-stage, WIDTH-bit shift register with synchronous active-low clear.
// Ports: clk, rst_n (sync, active low), d (input word), q (d delayed DEPTH cycles).
module ctrl_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk)
    if (!rst_n) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/mac_neuron_unit.sv
// mac_neuron_unit: signed MAC, scale, saturate (optional ReLU) and write one output neuron.
// Ports: clk, rst_n (sync, active low), bus (mac_neuron_unit_if.slave): control_unit strobes
// and memory read data in; output-neuron write port, layer_done and sticky acc_overflow out.
// Build option: define MAC_RELU_EN to write negative results as 0.
module mac_neuron_unit #(
  parameter int DATA_W    = mlp_pkg::DATA_W,
  parameter int ADDR_W    = mlp_pkg::ADDR_W,
  parameter int ACC_W     = mlp_pkg::ACC_W,
  parameter int FRAC_BITS = mlp_pkg::FRAC_BITS,
  parameter int MEM_LAT   = 1
) (
  input logic            clk,
  input logic            rst_n,
  mac_neuron_unit_if.slave bus
);
  localparam logic signed [ACC_W-1:0] acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] out_max = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] out_min = ACC_W'(-(2 ** (DATA_W - 1)));
  logic                     rm_d, wn_d, done_d;
  logic [ADDR_W-1:0]        addr_d;
  logic signed [ACC_W-1:0]  acc, acc_next, acc_sh;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]    sum;
  logic                     sum_ovf, wr_go;
  logic signed [DATA_W-1:0] out_sat, wr_val;
  logic                     wr_en_q, ovf_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic signed [DATA_W-1:0] wr_data_q;
  // Controls are delayed by the memory read latency so they meet their data words.
  ctrl_delay #(.WIDTH(ADDR_W + 3), .DEPTH(MEM_LAT)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({bus.reset_mult_acc, bus.write_neuron, bus.done, bus.output_neuron_addr}),
    .q     ({rm_d, wn_d, done_d, addr_d})
  );
  // One extra stage so layer_done lines up with the registered final write.
  ctrl_delay #(.WIDTH(1), .DEPTH(1)) u_done (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (done_d),
    .q     (bus.layer_done)
  );
  assign prod     = (2*DATA_W)'(bus.neuron_data) * (2*DATA_W)'(bus.weight_data);
  assign sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
  // One guard bit: a disagreement between the top two bits means the sum left ACC_W range.
  assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_next = sum_ovf ? (sum[ACC_W] ? acc_min : acc_max) : sum[ACC_W-1:0];
  assign acc_sh   = acc >>> FRAC_BITS;
  assign out_sat  = acc_sh > out_max ? out_max[DATA_W-1:0] :
                    acc_sh < out_min ? out_min[DATA_W-1:0] : acc_sh[DATA_W-1:0];
`ifdef MAC_RELU_EN
  assign wr_val   = out_sat[DATA_W-1] ? '0 : out_sat;
`else
  assign wr_val   = out_sat;
`endif
  assign wr_go    = wn_d && !rm_d;
  always_ff @(posedge clk)
    if (!rst_n) begin
      acc       <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      acc     <= rm_d ? '0 : wn_d ? acc : acc_next;
      ovf_q   <= ovf_q | (!rm_d && !wn_d && sum_ovf);
      wr_en_q <= wr_go;
      if (wr_go) begin
        wr_addr_q <= addr_d;
        wr_data_q <= wr_val;
      end
    end
  assign bus.neuron_wr_en   = wr_en_q;
  assign bus.neuron_wr_addr = wr_addr_q;
  assign bus.neuron_wr_data = wr_data_q;
  assign bus.acc_overflow   = ovf_q;
endmodule

// File: tb/tb_mac_neuron_unit.sv
// tb_mac_neuron_unit: directed self-checking bench for mac_neuron_unit (MEM_LAT = 1).
module tb_mac_neuron_unit;
`ifdef MAC_RELU_EN
  localparam bit relu = 1'b1;
`else
  localparam bit relu = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int pn = 0;
  int pw = 0;
  int wa_q[$];
  int wd_q[$];
  always #5 clk = ~clk;
  mac_neuron_unit_if #(.DATA_W(8), .ADDR_W(12)) bus ();
  mac_neuron_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always @(negedge clk)
    if (bus.neuron_wr_en) begin
      wa_q.push_back(int'(bus.neuron_wr_addr));
      wd_q.push_back(int'(bus.neuron_wr_data));
    end
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // One control_unit cycle; memory data returned now belongs to the previous cycle's address.
  task automatic cu(input int rm, input int wn, input int dn, input int a, input int n, input int w);
    bus.reset_mult_acc     = rm[0];
    bus.write_neuron       = wn[0];
    bus.done               = dn[0];
    bus.output_neuron_addr = a[11:0];
    bus.neuron_data        = pn[7:0];
    bus.weight_data        = pw[7:0];
    pn = n;
    pw = w;
    @(posedge clk);
    #1;
  endtask
  task automatic run_neuron(input string tag, input int a, input int n, input int w,
                            input int cnt, input int exp);
    cu(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < cnt; i++) cu(0, 0, 0, 0, n, w);
    cu(0, 1, 0, a, 0, 0);
    check({tag, "_early"}, int'(bus.neuron_wr_en), 0);
    cu(0, 0, 0, 0, 0, 0);
    check({tag, "_en"}, int'(bus.neuron_wr_en), 1);
    check({tag, "_addr"}, int'(bus.neuron_wr_addr), a);
    check({tag, "_data"}, int'(bus.neuron_wr_data), exp);
    cu(0, 0, 0, 0, 0, 0);
    check({tag, "_off"}, int'(bus.neuron_wr_en), 0);
  endtask
  int bn [3][3] = '{'{3, -5, 7}, '{100, 100, 100}, '{-8, 8, 127}};
  int bw [3][3] = '{'{20, 10, 4}, '{-2, -3, -4}, '{-8, -8, 127}};
  int bexp [3];
  initial begin
    bexp = '{2, relu ? 0 : -57, 127};
    cu(0, 0, 0, 0, 0, 0);
    cu(0, 0, 0, 0, 0, 0);
    check("rst_en", int'(bus.neuron_wr_en), 0);
    check("rst_addr", int'(bus.neuron_wr_addr), 0);
    check("rst_data", int'(bus.neuron_wr_data), 0);
    check("rst_ldone", int'(bus.layer_done), 0);
    check("rst_ovf", int'(bus.acc_overflow), 0);
    rst_n = 1'b1;
    cu(0, 0, 0, 0, 0, 0);
    run_neuron("basic", 12'h005, 16, 16, 4, 64);
    run_neuron("satpos", 12'h006, 127, 127, 4, 127);
    run_neuron("satneg", 12'h007, -128, 127, 4, relu ? 0 : -128);
    run_neuron("neg", 12'h008, -16, 16, 4, relu ? 0 : -64);
    check("neg_ovf", int'(bus.acc_overflow), 0);
    run_neuron("ovf", 12'h0ff, 127, 127, 600, 127);
    check("ovf_flag", int'(bus.acc_overflow), 1);
    cu(1, 0, 0, 0, 0, 0);
    cu(0, 0, 0, 0, 0, 0);
    check("ovf_sticky", int'(bus.acc_overflow), 1);
    cu(1, 0, 0, 0, 0, 0);
    cu(0, 0, 0, 0, 10, 10);
    cu(0, 0, 0, 0, 10, 10);
    cu(0, 1, 0, 12'h009, 0, 0);
    rst_n = 1'b0;
    cu(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check("mid_en", int'(bus.neuron_wr_en), 0);
    check("mid_addr", int'(bus.neuron_wr_addr), 0);
    check("mid_data", int'(bus.neuron_wr_data), 0);
    check("mid_ovf", int'(bus.acc_overflow), 0);
    cu(0, 0, 0, 0, 0, 0);
    check("mid_nowr0", int'(bus.neuron_wr_en), 0);
    cu(0, 0, 0, 0, 0, 0);
    check("mid_nowr1", int'(bus.neuron_wr_en), 0);
    for (int i = 0; i < 3; i++) cu(0, 0, 0, 0, 16, 16);
    cu(0, 1, 0, 12'h00a, 0, 0);
    cu(0, 0, 0, 0, 0, 0);
    check("post_en", int'(bus.neuron_wr_en), 1);
    check("post_addr", int'(bus.neuron_wr_addr), 12'h00a);
    check("post_data", int'(bus.neuron_wr_data), 48);
    cu(0, 0, 0, 0, 0, 0);
    wa_q.delete();
    wd_q.delete();
    for (int j = 0; j < 3; j++) begin
      cu(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cu(0, 0, 0, 0, bn[j][i], bw[j][i]);
      cu(0, 1, 0, 12'h010 + j, 0, 0);
    end
    cu(0, 0, 1, 0, 0, 0);
    check("ldone_d1", int'(bus.layer_done), 0);
    cu(0, 0, 0, 0, 0, 0);
    check("ldone_d2", int'(bus.layer_done), 1);
    check("ldone_after_wr", wa_q.size(), 3);
    cu(0, 0, 0, 0, 0, 0);
    check("ldone_drop", int'(bus.layer_done), 0);
    cu(0, 0, 0, 0, 0, 0);
    check("b2b_count", wa_q.size(), 3);
    for (int j = 0; j < 3 && j < wa_q.size(); j++) begin
      check($sformatf("b2b_addr%0d", j), wa_q[j], 12'h010 + j);
      check($sformatf("b2b_data%0d", j), wd_q[j], bexp[j]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_neuron_unit.md
Name: mac_neuron_unit

Overview:
- Datapath stage directly downstream of control_unit in mlp_v1.
- Consumes control_unit's strobes plus the neuron and weight words read from memory at control_unit's addresses. Performs the signed multiply-accumulate, then scaling, saturation and optional ReLU.
- Produces the write port into the output-neuron memory, plus a delayed layer-done flag.

Parameters:
- DATA_W, 8, signed width of neuron and weight words and of written neuron.
- ADDR_W, 12, neuron address width (matches control_unit).
- ACC_W, 24, signed accumulator width.
- FRAC_BITS, 4, arithmetic right shift applied to the accumulator before output saturation.
- MEM_LAT, 1, read latency (cycles) of the neuron/weight memories; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- reset_mult_acc  in  1  from control_unit: start of a new output neuron.
- write_neuron  in  1  from control_unit: current neuron's sum complete.
- output_neuron_addr  in  ADDR_W  from control_unit: destination of current neuron.
- done  in  1  from control_unit: layer complete.
- neuron_data  in  DATA_W  signed input neuron from memory, MEM_LAT after address.
- weight_data  in  DATA_W  signed weight from memory, MEM_LAT after address.
- neuron_wr_en  out  1  output-neuron memory write strobe.
- neuron_wr_addr  out  ADDR_W  write address.
- neuron_wr_data  out  DATA_W  written neuron value.
- layer_done  out  1  done, aligned after the final write.
- acc_overflow  out  1  sticky accumulator saturation flag.

Behaviour:
- Reset: rst_n=0 at a rising edge clears every output, the accumulator and all delay-line stages to 0. This applies mid-layer too.
  - No spurious write after release; the first write needs a fresh write_neuron.
- Alignment: reset_mult_acc, write_neuron, output_neuron_addr and done are delayed MEM_LAT cycles so they line up with neuron_data/weight_data. The delayed copies are suffixed _d below.
- Accumulator update, evaluated at each edge with delayed controls (priority order):
  - reset_mult_acc_d=1: acc <= 0. The product is discarded; reset wins over write_neuron_d if both are set.
  - else write_neuron_d=1: acc is held and the product is discarded. The write is issued from the current acc.
  - else: acc <= sat_ACC(acc + sext(neuron_data*weight_data)).
- Arithmetic widths:
  - Product is the full 2*DATA_W signed result, sign-extended to ACC_W.
  - If the sum exceeds the ACC_W signed range, acc clamps to the max or min value and acc_overflow is set.
  - acc_overflow is sticky; only rst_n clears it.
- Write path (registered): on write_neuron_d=1 and reset_mult_acc_d=0, the next cycle drives:
  - neuron_wr_en=1;
  - neuron_wr_addr = output_neuron_addr_d;
  - neuron_wr_data = sat_DATA(acc >>> FRAC_BITS), where the shift is arithmetic and saturation is to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Otherwise neuron_wr_en=0. Address and data hold their last values.
- Latency: write_neuron at control-unit cycle t gives neuron_wr_en high during cycle t+MEM_LAT+1.
- layer_done = done delayed MEM_LAT+1 cycles. It follows done (not sticky) and is never earlier than the last write.
- Back-to-back neurons: write_neuron followed by reset_mult_acc on the next cycle is legal, with no bubble required. Two consecutive write_neuron cycles write the same value twice.

Optional Feature:
- MAC_RELU_EN defined: after saturation, negative results are written as 0.
- MAC_RELU_EN undefined: the signed saturated value is written unchanged.

Decomposition:
- Package mlp_pkg holds DATA_W, ADDR_W, ACC_W and FRAC_BITS defaults, and the saturation-limit constants.
- Sub-module ctrl_delay: parameterised-depth, parameterised-width shift register with synchronous active-low clear.
  - Instantiated once for {reset_mult_acc, write_neuron, done, output_neuron_addr} at depth MEM_LAT.
  - Instantiated once more for the extra done stage.

Test Plan:
- Basic sum: reset, then 4 MAC cycles with neuron=16 and weight=16, then write_neuron at addr 0x005 -> one write, addr 0x005, data 64 (1024>>>4), at t+2.
- Output saturation: 4 MACs with 127×127 -> data 127; 4 MACs with -128×127 -> -128 without MAC_RELU_EN, 0 with it.
- Negative, no saturation: 4 MACs with -16×16 -> -64 without MAC_RELU_EN, 0 with it; acc_overflow stays 0.
- Accumulator overflow: 600 MACs with 127×127 -> acc clamps at 8388607, acc_overflow=1 and remains 1 after the next reset_mult_acc, written data 127.
- Reset mid-neuron: rst_n low for 1 cycle between MACs 2 and 3 -> all outputs 0, no write occurs until the next write_neuron, next neuron sum excludes pre-reset products.
- Back-to-back neurons via the control_unit bench sequence: writes at consecutive addresses, each value matching a reference model; layer_done rises exactly 2 cycles after done.
